// File: rtl/gol_pkg.sv
// Shared types, constants and helpers for the Game-of-Life board store.
package gol_pkg;

    // Board controller states: normal update traffic or seed loading.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } gol_state_e;

    // Glider seed, occupying bits [2:0] of rows 0..2 after reset.
    localparam logic [2:0] GLIDER_ROW0 = 3'b010;
    localparam logic [2:0] GLIDER_ROW1 = 3'b001;
    localparam logic [2:0] GLIDER_ROW2 = 3'b111;

    // Next row index on a torus of n rows.
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

    // Previous row index on a torus of n rows.
    function automatic logic [31:0] wrap_dec(input logic [31:0] idx, input logic [31:0] n);
        if (idx == 32'd0) begin
            return n - 32'd1;
        end else begin
            return idx - 32'd1;
        end
    endfunction

endpackage

// File: rtl/gol_bank.sv
// One ROWS x WIDTH board bank: single synchronous write port, async reset
// to either the glider seed or all-zero, contents exposed flattened.
module gol_bank
    import gol_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ROWS        = 8,
    parameter int REGBITS     = $clog2(ROWS),
    parameter bit INIT_GLIDER = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [REGBITS-1:0]      wa_i,
    input  logic [WIDTH-1:0]        wd_i,
    output logic [ROWS*WIDTH-1:0]   rows_o
);

    logic [WIDTH-1:0] mem_q [ROWS];
    logic             wa_ok_s;

    // Reset value of a given row for this bank.
    function automatic logic [WIDTH-1:0] init_row(input int r);
        logic [WIDTH-1:0] v;
        v = '0;
        if (INIT_GLIDER) begin
            if (r == 32'sd0) begin
                v[2:0] = GLIDER_ROW0;
            end else if (r == 32'sd1) begin
                v[2:0] = GLIDER_ROW1;
            end else if (r == 32'sd2) begin
                v[2:0] = GLIDER_ROW2;
            end else begin
                v = '0;
            end
        end else begin
            v = '0;
        end
        return v;
    endfunction

    assign wa_ok_s = (32'(wa_i) < ROWS);

    // Row storage: reset to the seed pattern, otherwise accept in-range writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= init_row(r);
            end
        end else if (we_i && wa_ok_s) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_flat
        assign rows_o[g*WIDTH +: WIDTH] = mem_q[g];
    end

endmodule

// File: rtl/gol_board_state.sv
// Double-buffered Game-of-Life board: current/next banks, toroidal row
// reads, seed loader, generation counter and stability/liveness status.
module gol_board_state
    import gol_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ROWS    = 8,
    parameter int REGBITS = $clog2(ROWS),
    parameter int GENBITS = 16
) (
    input  logic               ph2,
    input  logic               reset_n,
    input  logic [REGBITS-1:0] ra,
    output logic [WIDTH-1:0]   rd_above,
    output logic [WIDTH-1:0]   rd_cur,
    output logic [WIDTH-1:0]   rd_below,
    input  logic               we,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic               swap,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [WIDTH-1:0]   load_data,
    output logic               load_ready,
    output logic               busy,
    output logic [GENBITS-1:0] gen_count,
    output logic               alive,
    output logic               stable
);

    gol_state_e         state_q, state_d;
    logic               bank_sel_q, bank_sel_d;
    logic [REGBITS-1:0] lp_q, lp_d;
    logic [GENBITS-1:0] gen_q, gen_d;
    logic               stable_q, stable_d;

    logic [ROWS*WIDTH-1:0] rows0_s, rows1_s, cur_rows_s, nxt_rows_s;
    logic                  wr_en_s, wr_bank_s, we0_s, we1_s;
    logic [REGBITS-1:0]    wr_addr_s;
    logic [WIDTH-1:0]      wr_data_s;
    logic                  ra_ok_s;
    logic [REGBITS-1:0]    ra_up_s, ra_dn_s;

    gol_bank #(
        .WIDTH(WIDTH), .ROWS(ROWS), .REGBITS(REGBITS), .INIT_GLIDER(1'b1)
    ) u_bank0 (
        .clk(ph2), .rst_n(reset_n), .we_i(we0_s), .wa_i(wr_addr_s),
        .wd_i(wr_data_s), .rows_o(rows0_s)
    );

    gol_bank #(
        .WIDTH(WIDTH), .ROWS(ROWS), .REGBITS(REGBITS), .INIT_GLIDER(1'b0)
    ) u_bank1 (
        .clk(ph2), .rst_n(reset_n), .we_i(we1_s), .wa_i(wr_addr_s),
        .wd_i(wr_data_s), .rows_o(rows1_s)
    );

    assign cur_rows_s = bank_sel_q ? rows1_s : rows0_s;
    assign nxt_rows_s = bank_sel_q ? rows0_s : rows1_s;

    // Write steering: the loader fills the current bank, the engine the next one.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_bank_s = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (state_q == ST_LOAD) begin
            wr_en_s   = load_valid;
            wr_bank_s = bank_sel_q;
            wr_addr_s = lp_q;
            wr_data_s = load_data;
        end else begin
            wr_en_s   = we;
            wr_bank_s = ~bank_sel_q;
            wr_addr_s = wa;
            wr_data_s = wd;
        end
        we0_s = wr_en_s && (wr_bank_s == 1'b0);
        we1_s = wr_en_s && (wr_bank_s == 1'b1);
    end

    // Controller next state: swaps and load start in IDLE, row handshakes in LOAD.
    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        lp_d       = lp_q;
        gen_d      = gen_q;
        stable_d   = stable_q;
        case (state_q)
            ST_IDLE: begin
                if (swap) begin
                    bank_sel_d = ~bank_sel_q;
                    gen_d      = gen_q + GENBITS'(1'b1);
                    stable_d   = (nxt_rows_s == cur_rows_s);
                end else begin
                    bank_sel_d = bank_sel_q;
                end
                if (load_start) begin
                    state_d = ST_LOAD;
                    lp_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    if (32'(lp_q) == ROWS - 1) begin
                        state_d  = ST_IDLE;
                        lp_d     = '0;
                        gen_d    = '0;
                        stable_d = 1'b0;
                    end else begin
                        lp_d = lp_q + REGBITS'(1'b1);
                    end
                end else begin
                    lp_d = lp_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lp_d    = '0;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge ph2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bank_sel_q <= 1'b0;
            lp_q       <= '0;
            gen_q      <= '0;
            stable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            lp_q       <= lp_d;
            gen_q      <= gen_d;
            stable_q   <= stable_d;
        end
    end

    assign ra_ok_s = (32'(ra) < ROWS);
    assign ra_up_s = REGBITS'(wrap_dec(32'(ra), 32'(ROWS)));
    assign ra_dn_s = REGBITS'(wrap_inc(32'(ra), 32'(ROWS)));

    // Toroidal neighbour-row reads from the current bank; out-of-range rows read 0.
    always_comb begin
        if (ra_ok_s) begin
            rd_above = cur_rows_s[32'(ra_up_s)*WIDTH +: WIDTH];
            rd_cur   = cur_rows_s[32'(ra)*WIDTH +: WIDTH];
            rd_below = cur_rows_s[32'(ra_dn_s)*WIDTH +: WIDTH];
        end else begin
            rd_above = '0;
            rd_cur   = '0;
            rd_below = '0;
        end
    end

    assign load_ready = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD);
    assign gen_count  = gen_q;
    assign alive      = |cur_rows_s;
    assign stable     = stable_q;

endmodule
